// File: rtl/flyback_sequencer.sv
// -----------------------------------------------------------------------------
// flyback_sequencer
// Closed-loop supervisor for the flyback PWM generator. The block handles:
//   - power-up through a stepped soft-start;
//   - regulation, moving the 2-bit duty code one step per switching period
//     from the vout_low comparator;
//   - counting consecutive over-current periods, and forcing the converter
//     off on a fault.
// The PWM generator's period-wrap pulse is the regulation timebase.
//
// Optional build macro: FLYBACK_SEQ_AUTO_RETRY_EN
//   defined   : FAULT -> COOLDOWN (COOLDOWN_CYCLES clk) -> retry/idle
//   undefined : FAULT latches until enable_i drops; COOLDOWN is not built
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   enable_i          run request (1 = start/run)
//   period_start_i    one-clk pulse at each PWM period wrap
//   vout_low_async_i  async comparator, 1 = output below target
//   ocp_async_i       async comparator, 1 = switch over-current
//   duty_o            duty code to the PWM generator
//   pwm_en_o          PWM generator enable
//   state_o           FSM state encoding
//   fault_o           fault indicator
//   pgood_o           power good
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module flyback_sequencer #(
    parameter int unsigned SS_PERIODS      = 16,
    parameter int unsigned FAULT_LIMIT     = 3,
    parameter int unsigned COOLDOWN_CYCLES = 2000,
    parameter int unsigned CNT_W           = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       period_start_i,
    input  logic       vout_low_async_i,
    input  logic       ocp_async_i,
    output logic [1:0] duty_o,
    output logic       pwm_en_o,
    output logic [2:0] state_o,
    output logic       fault_o,
    output logic       pgood_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_SOFTSTART = 3'b001,
        ST_REGULATE  = 3'b010,
        ST_FAULT     = 3'b011,
        ST_COOLDOWN  = 3'b100
    } state_e;

    localparam int unsigned      OCP_W    = $clog2(FAULT_LIMIT + 1);
    localparam logic [CNT_W-1:0] SS_LAST  = CNT_W'(SS_PERIODS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [OCP_W-1:0] OCP_MAX  = OCP_W'(FAULT_LIMIT);
    localparam logic [OCP_W-1:0] OCP_ONE  = OCP_W'(1);
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
`endif

    state_e           state_q, state_d;
    logic [1:0]       duty_q, duty_d;
    logic             pwm_en_q, pwm_en_d;
    logic             fault_q, fault_d;
    logic             pgood_q, pgood_d;
    logic [CNT_W-1:0] ss_cnt_q, ss_cnt_d;
    logic [OCP_W-1:0] ocp_cnt_q, ocp_cnt_d;
    logic             ocp_seen_q, ocp_seen_d;
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
    logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
`endif
    logic [1:0]       vl_sync_q, oc_sync_q;
    logic             vl_s, oc_s;
    logic             running_s, ocp_hit_s, fault_now_s;
    logic [OCP_W-1:0] ocp_inc_s;

    assign vl_s = vl_sync_q[1];
    assign oc_s = oc_sync_q[1];

    // Two-flop synchronizers for the asynchronous comparator inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_sync_q <= 2'b00;
            oc_sync_q <= 2'b00;
        end else begin
            vl_sync_q <= {vl_sync_q[0], vout_low_async_i};
            oc_sync_q <= {oc_sync_q[0], ocp_async_i};
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        pwm_en_d   = pwm_en_q;
        fault_d    = fault_q;
        ss_cnt_d   = ss_cnt_q;
        ocp_cnt_d  = ocp_cnt_q;
        ocp_seen_d = ocp_seen_q;
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
        cd_cnt_d   = cd_cnt_q;
`endif

        running_s   = (state_q == ST_SOFTSTART) || (state_q == ST_REGULATE);
        // A period counts as over-current if the sticky flag caught it or the
        // comparator is asserted on the period boundary itself.
        ocp_hit_s   = ocp_seen_q | oc_s;
        ocp_inc_s   = (ocp_cnt_q == OCP_MAX) ? OCP_MAX : (ocp_cnt_q + OCP_ONE);
        fault_now_s = period_start_i && ocp_hit_s && (ocp_inc_s == OCP_MAX);

        // Over-current bookkeeping only runs while switching; a set in the
        // same cycle as the period clear wins.
        if (running_s) begin
            if (oc_s) begin
                ocp_seen_d = 1'b1;
            end else if (period_start_i) begin
                ocp_seen_d = 1'b0;
            end else begin
                ocp_seen_d = ocp_seen_q;
            end
            if (period_start_i) begin
                ocp_cnt_d = ocp_hit_s ? ocp_inc_s : {OCP_W{1'b0}};
            end else begin
                ocp_cnt_d = ocp_cnt_q;
            end
        end else begin
            ocp_seen_d = 1'b0;
            ocp_cnt_d  = {OCP_W{1'b0}};
        end

        case (state_q)
            ST_IDLE: begin
                duty_d   = 2'b00;
                fault_d  = 1'b0;
                ss_cnt_d = {CNT_W{1'b0}};
                if (enable_i) begin
                    state_d  = ST_SOFTSTART;
                    pwm_en_d = 1'b1;
                end else begin
                    pwm_en_d = 1'b0;
                end
            end
            ST_SOFTSTART, ST_REGULATE: begin
                if (!enable_i) begin
                    state_d  = ST_IDLE;
                    pwm_en_d = 1'b0;
                    duty_d   = 2'b00;
                end else if (!period_start_i) begin
                    state_d  = state_q;
                end else if (fault_now_s) begin
                    state_d  = ST_FAULT;
                    pwm_en_d = 1'b0;
                    duty_d   = 2'b00;
                    fault_d  = 1'b1;
                end else if (state_q == ST_REGULATE) begin
                    // Saturating one-step regulation per period.
                    if (vl_s) begin
                        duty_d = (duty_q != 2'b11) ? (duty_q + 2'b01) : duty_q;
                    end else begin
                        duty_d = (duty_q != 2'b00) ? (duty_q - 2'b01) : duty_q;
                    end
                end else if (!vl_s) begin
                    // Output already in regulation: leave soft-start early.
                    state_d = ST_REGULATE;
                end else if (ss_cnt_q == SS_LAST) begin
                    if (duty_q != 2'b11) begin
                        duty_d   = duty_q + 2'b01;
                        ss_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d  = ST_REGULATE;
                    end
                end else begin
                    ss_cnt_d = ss_cnt_q + CNT_ONE;
                end
            end
            ST_FAULT: begin
                pwm_en_d = 1'b0;
                duty_d   = 2'b00;
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
                state_d  = ST_COOLDOWN;
                cd_cnt_d = {CNT_W{1'b0}};
`else
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end else begin
                    fault_d = 1'b1;
                end
`endif
            end
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
            ST_COOLDOWN: begin
                duty_d = 2'b00;
                if (cd_cnt_q == CD_LAST) begin
                    fault_d  = 1'b0;
                    ss_cnt_d = {CNT_W{1'b0}};
                    if (enable_i) begin
                        state_d  = ST_SOFTSTART;
                        pwm_en_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        pwm_en_d = 1'b0;
                    end
                end else begin
                    cd_cnt_d = cd_cnt_q + CNT_ONE;
                    pwm_en_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                duty_d   = 2'b00;
                pwm_en_d = 1'b0;
                fault_d  = 1'b0;
                ss_cnt_d = {CNT_W{1'b0}};
            end
        endcase

        // Power good needs a full cycle in REGULATE and drops on the same edge
        // as any exit from it.
        pgood_d = (state_q == ST_REGULATE) && (state_d == ST_REGULATE) && !vl_s;
    end

    // State, counter and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            duty_q     <= 2'b00;
            pwm_en_q   <= 1'b0;
            fault_q    <= 1'b0;
            pgood_q    <= 1'b0;
            ss_cnt_q   <= {CNT_W{1'b0}};
            ocp_cnt_q  <= {OCP_W{1'b0}};
            ocp_seen_q <= 1'b0;
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
            cd_cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            pwm_en_q   <= pwm_en_d;
            fault_q    <= fault_d;
            pgood_q    <= pgood_d;
            ss_cnt_q   <= ss_cnt_d;
            ocp_cnt_q  <= ocp_cnt_d;
            ocp_seen_q <= ocp_seen_d;
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
            cd_cnt_q   <= cd_cnt_d;
`endif
        end
    end

    assign state_o  = state_q;
    assign duty_o   = duty_q;
    assign pwm_en_o = pwm_en_q;
    assign fault_o  = fault_q;
    assign pgood_o  = pgood_q;

endmodule

// File: tb/tb_flyback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flyback_sequencer
// Directed, self-checking bench for flyback_sequencer with default parameters
// (SS_PERIODS=16, FAULT_LIMIT=3, COOLDOWN_CYCLES=2000). The fault recovery
// checks follow whichever FLYBACK_SEQ_AUTO_RETRY_EN build is compiled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flyback_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable_i;
    logic       period_start_i;
    logic       vout_low_async_i;
    logic       ocp_async_i;
    logic [1:0] duty_o;
    logic       pwm_en_o;
    logic [2:0] state_o;
    logic       fault_o;
    logic       pgood_o;

    int compared;
    int mismatched;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_SS   = 3'b001;
    localparam logic [2:0] S_REG  = 3'b010;
    localparam logic [2:0] S_FLT  = 3'b011;
    localparam logic [2:0] S_CD   = 3'b100;

    flyback_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_i         (enable_i),
        .period_start_i   (period_start_i),
        .vout_low_async_i (vout_low_async_i),
        .ocp_async_i      (ocp_async_i),
        .duty_o           (duty_o),
        .pwm_en_o         (pwm_en_o),
        .state_o          (state_o),
        .fault_o          (fault_o),
        .pgood_o          (pgood_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        period_start_i = 1'b1;
        tick();
        period_start_i = 1'b0;
    endtask

    // One switching period with an optional 1-clk over-current glitch.
    task automatic ocp_period(input logic hit);
        repeat (2) tick();
        ocp_async_i = hit;
        tick();
        ocp_async_i = 1'b0;
        repeat (4) tick();
        pulse();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; enable_i = 1'b0; period_start_i = 1'b0;
        vout_low_async_i = 1'b0; ocp_async_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if (state_o !== S_IDLE || duty_o !== 2'b00 || pwm_en_o !== 1'b0 ||
            fault_o !== 1'b0 || pgood_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: state=%b duty=%b pwm=%b fault=%b pgood=%b, want 000/00/0/0/0",
                     state_o, duty_o, pwm_en_o, fault_o, pgood_o);
        end
        repeat (2) tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_softstart_full();
        logic [1:0] exp_duty;
        vout_low_async_i = 1'b1;
        repeat (3) tick();
        enable_i = 1'b1;
        tick();
        compared++;
        if (state_o !== S_SS || pwm_en_o !== 1'b1 || duty_o !== 2'b00) begin
            mismatched++;
            $display("FAIL ss_entry: state=%b pwm=%b duty=%b, want 001/1/00", state_o, pwm_en_o, duty_o);
        end
        for (int p = 1; p <= 64; p++) begin
            repeat (3) tick();
            pulse();
            exp_duty = (p >= 48) ? 2'b11 : 2'(p / 16);
            compared++;
            if (duty_o !== exp_duty) begin
                mismatched++;
                $display("FAIL ss_duty_p%0d: got %b, want %b", p, duty_o, exp_duty);
            end
            if (p == 63 || p == 64) begin
                compared++;
                if (state_o !== ((p == 64) ? S_REG : S_SS)) begin
                    mismatched++;
                    $display("FAIL ss_state_p%0d: got %b, want %b", p, state_o,
                             (p == 64) ? S_REG : S_SS);
                end
            end
        end
        repeat (3) tick();
        pulse();
        compared++;
        if (duty_o !== 2'b11 || state_o !== S_REG || pgood_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reg_sat_high: duty=%b state=%b pgood=%b, want 11/010/0", duty_o, state_o, pgood_o);
        end
    endtask

    task automatic test_regulate();
        logic [1:0] exp_duty;
        logic [1:0] want [0:2];
        want[0] = 2'b10; want[1] = 2'b11; want[2] = 2'b10;
        // Alternate low/high/low: 11 -> 10 -> 11 -> 10.
        for (int i = 0; i < 3; i++) begin
            vout_low_async_i = (i == 1);
            repeat (3) tick();
            pulse();
            compared++;
            if (duty_o !== want[i]) begin
                mismatched++;
                $display("FAIL reg_alt_%0d: got %b, want %b", i, duty_o, want[i]);
            end
        end
        vout_low_async_i = 1'b1;
        repeat (3) tick();
        pulse();
        vout_low_async_i = 1'b0;
        exp_duty = 2'b11;
        for (int i = 0; i < 5; i++) begin
            repeat (3) tick();
            pulse();
            if (exp_duty != 2'b00) exp_duty = exp_duty - 2'b01;
            compared++;
            if (duty_o !== exp_duty || pgood_o !== 1'b1) begin
                mismatched++;
                $display("FAIL reg_down_%0d: duty=%b pgood=%b, want %b/1", i, duty_o, pgood_o, exp_duty);
            end
        end
    endtask

    task automatic test_reset_mid_regulate();
        vout_low_async_i = 1'b1;
        repeat (3) tick();
        pulse();
        repeat (3) tick();
        pulse();
        compared++;
        if (duty_o !== 2'b10 || state_o !== S_REG) begin
            mismatched++;
            $display("FAIL pre_reset_duty: duty=%b state=%b, want 10/010", duty_o, state_o);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (duty_o !== 2'b00 || pwm_en_o !== 1'b0 || state_o !== S_IDLE) begin
            mismatched++;
            $display("FAIL async_reset: duty=%b pwm=%b state=%b, want 00/0/000", duty_o, pwm_en_o, state_o);
        end
        enable_i = 1'b0;
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_softstart_early_exit();
        vout_low_async_i = 1'b1;
        repeat (3) tick();
        enable_i = 1'b1;
        tick();
        for (int p = 0; p < 16; p++) begin
            repeat (3) tick();
            pulse();
        end
        compared++;
        if (duty_o !== 2'b01 || state_o !== S_SS) begin
            mismatched++;
            $display("FAIL early_pre: duty=%b state=%b, want 01/001", duty_o, state_o);
        end
        vout_low_async_i = 1'b0;
        pulse();
        compared++;
        if (state_o !== S_SS) begin
            mismatched++;
            $display("FAIL early_sync_lag: state=%b, want 001", state_o);
        end
        tick();
        pulse();
        compared++;
        if (state_o !== S_REG || duty_o !== 2'b01 || pgood_o !== 1'b0) begin
            mismatched++;
            $display("FAIL early_exit: state=%b duty=%b pgood=%b, want 010/01/0", state_o, duty_o, pgood_o);
        end
        tick();
        compared++;
        if (pgood_o !== 1'b1) begin
            mismatched++;
            $display("FAIL early_pgood: got %b, want 1", pgood_o);
        end
    endtask

    task automatic test_ocp_fault();
        int n;
        for (int k = 1; k <= 3; k++) begin
            ocp_period(1'b1);
            compared++;
            if (state_o !== ((k == 3) ? S_FLT : S_REG) || fault_o !== (k == 3)) begin
                mismatched++;
                $display("FAIL ocp_period_%0d: state=%b fault=%b, want %b/%0d", k, state_o, fault_o,
                         (k == 3) ? S_FLT : S_REG, (k == 3));
            end
        end
        compared++;
        if (pwm_en_o !== 1'b0 || duty_o !== 2'b00 || pgood_o !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_outputs: pwm=%b duty=%b pgood=%b, want 0/00/0", pwm_en_o, duty_o, pgood_o);
        end
`ifdef FLYBACK_SEQ_AUTO_RETRY_EN
        tick();
        compared++;
        if (state_o !== S_CD || fault_o !== 1'b1) begin
            mismatched++;
            $display("FAIL cooldown_entry: state=%b fault=%b, want 100/1", state_o, fault_o);
        end
        n = 1;
        while (state_o !== S_SS && n < 2100) begin
            tick();
            n++;
        end
        compared++;
        if (n !== 2001 || fault_o !== 1'b0 || pwm_en_o !== 1'b1 || duty_o !== 2'b00) begin
            mismatched++;
            $display("FAIL cooldown_retry: cycles=%0d fault=%b pwm=%b duty=%b, want 2001/0/1/00",
                     n, fault_o, pwm_en_o, duty_o);
        end
        enable_i = 1'b0;
        tick();
`else
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) pulse(); else tick();
            if (state_o === S_FLT && fault_o === 1'b1 && pwm_en_o === 1'b0) n++;
        end
        compared++;
        if (n !== 10) begin
            mismatched++;
            $display("FAIL fault_latch: held %0d of 10 cycles, want 10", n);
        end
        enable_i = 1'b0;
        tick();
`endif
        compared++;
        if (state_o !== S_IDLE || fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_exit: state=%b fault=%b, want 000/0", state_o, fault_o);
        end
    endtask

    task automatic test_ocp_nonconsecutive();
        logic [5:0] pat;
        logic [2:0] exp_state;
        pat = 6'b111011;
        vout_low_async_i = 1'b0;
        repeat (3) tick();
        enable_i = 1'b1;
        tick();
        repeat (3) tick();
        pulse();
        compared++;
        if (state_o !== S_REG) begin
            mismatched++;
            $display("FAIL nc_entry: state=%b, want 010", state_o);
        end
        for (int i = 0; i < 6; i++) begin
            ocp_period(pat[i]);
            exp_state = (i == 5) ? S_FLT : S_REG;
            compared++;
            if (state_o !== exp_state) begin
                mismatched++;
                $display("FAIL nc_period_%0d: state=%b, want %b", i, state_o, exp_state);
            end
        end
    endtask

    task automatic test_enable_drop();
        enable_i = 1'b0;
        vout_low_async_i = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        enable_i = 1'b1;
        tick();
        pulse();
        repeat (2) tick();
        compared++;
        if (state_o !== S_REG || pgood_o !== 1'b1) begin
            mismatched++;
            $display("FAIL drop_pre: state=%b pgood=%b, want 010/1", state_o, pgood_o);
        end
        enable_i = 1'b0;
        pulse();
        compared++;
        if (state_o !== S_IDLE || duty_o !== 2'b00 || pwm_en_o !== 1'b0 || pgood_o !== 1'b0) begin
            mismatched++;
            $display("FAIL drop_idle: state=%b duty=%b pwm=%b pgood=%b, want 000/00/0/0",
                     state_o, duty_o, pwm_en_o, pgood_o);
        end
        pulse();
        compared++;
        if (state_o !== S_IDLE || pwm_en_o !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ignores_period: state=%b pwm=%b, want 000/0", state_o, pwm_en_o);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_softstart_full();
        test_regulate();
        test_reset_mid_regulate();
        test_softstart_early_exit();
        test_ocp_fault();
        test_ocp_nonconsecutive();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
